// File: rtl/mem_fill_pkg.sv
// Shared types and default sizing for the cache-block fill controller.
// The state enum is shared so the controller and any observers agree on its encoding.
package mem_fill_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    WAIT = 2'd2
  } fill_state_e;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_WORDS  = 8;
  localparam int DEF_NUM_CH = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the channel after the last accepted grant has top priority.
// It produces a one-hot grant and its binary index.
module rr_arbiter #(
  parameter int NUM_CH = 2,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req,
  input  logic              accept,
  output logic [NUM_CH-1:0] grant,
  output logic [CH_W-1:0]   grant_idx
);

  logic [CH_W-1:0] prio;
  int              rank;
  int              best_rank;

  // The winner is the requester with the smallest distance from the priority pointer.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    rank      = 0;
    best_rank = NUM_CH;
    for (int j = 0; j < NUM_CH; j++) begin
      rank = j - int'(prio);
      if (rank < 0) rank = rank + NUM_CH;
      if (req[j] && (rank < best_rank)) begin
        best_rank = rank;
        grant_idx = CH_W'(j);
      end
    end
    if (best_rank < NUM_CH) grant[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio <= '0;
    end else if (accept && (|req)) begin
      prio <= (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/mem_fill_ctrl.sv
// Cache-block fill controller: arbitrates miss requests, issues a burst of word reads
// and streams the returned words into the granted channel's cache.
module mem_fill_ctrl
  import mem_fill_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int WORDS  = DEF_WORDS,
  parameter int NUM_CH = DEF_NUM_CH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0]          miss_req,
  input  logic [NUM_CH*ADDR_W-1:0]   miss_addr,
  output logic                       mem_en,
  output logic [ADDR_W-1:0]          mem_addr,
  input  logic                       mem_valid,
  input  logic [DATA_W-1:0]          mem_data,
  output logic [NUM_CH-1:0]          fill_valid,
  output logic [$clog2(WORDS)-1:0]   fill_word,
  output logic [DATA_W-1:0]          fill_data,
  output logic [NUM_CH-1:0]          fill_done,
  output logic [NUM_CH-1:0]          stall
);

  localparam int BYTES = DATA_W / 8;
  localparam int IDX_W = $clog2(WORDS);
  localparam int CNT_W = IDX_W + 1;
  localparam int OFF_W = $clog2(WORDS * BYTES);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [ADDR_W-1:0] BASE_MASK  = {ADDR_W{1'b1}} << OFF_W;
  localparam logic [CNT_W-1:0]  ISSUE_END  = CNT_W'(WORDS);
  localparam logic [IDX_W-1:0]  RECV_LAST  = IDX_W'(WORDS - 1);

  fill_state_e       state;
  fill_state_e       next_state;
  logic [CNT_W-1:0]  issue_cnt;
  logic [IDX_W-1:0]  recv_cnt;
  logic [CH_W-1:0]   grant;
  logic [ADDR_W-1:0] block_base;

  logic              accept;
  logic [NUM_CH-1:0] arb_grant;
  logic [CH_W-1:0]   arb_idx;
  logic [ADDR_W-1:0] req_addr;

  assign accept = (state == IDLE) && (|miss_req);

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (miss_req),
    .accept    (accept),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  // One-hot AND-OR select of the winning channel's miss address.
  always_comb begin
    req_addr = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (arb_grant[c]) req_addr = req_addr | miss_addr[c*ADDR_W +: ADDR_W];
    end
  end

  // Issue runs ahead of receive; the two counters advance independently.
  assign mem_en    = (state == FILL) && (issue_cnt < ISSUE_END);
  assign mem_addr  = block_base + ADDR_W'(32'(issue_cnt) * BYTES);
  assign fill_word = recv_cnt;
  assign fill_data = mem_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      issue_cnt  <= '0;
      recv_cnt   <= '0;
      grant      <= '0;
      block_base <= '0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (accept) begin
            grant      <= arb_idx;
            block_base <= req_addr & BASE_MASK;
            issue_cnt  <= '0;
            recv_cnt   <= '0;
          end
        end
        FILL: begin
          if (mem_en)    issue_cnt <= issue_cnt + 1'b1;
          if (mem_valid) recv_cnt  <= recv_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Write strobes exist only in FILL, so stray memory responses elsewhere are dropped.
  always_comb begin
    next_state = state;
    fill_valid = '0;
    fill_done  = '0;
    case (state)
      IDLE: begin
        if (|miss_req) next_state = FILL;
      end
      FILL: begin
        if (mem_valid) begin
          fill_valid[grant] = 1'b1;
          if (recv_cnt == RECV_LAST) begin
            fill_done[grant] = 1'b1;
            next_state       = WAIT;
          end
        end
      end
      WAIT: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_comb begin
    stall = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      stall[c] = miss_req[c] | ((state != IDLE) && (grant == CH_W'(c)));
    end
  end

endmodule

// File: tb/tb_mem_fill_ctrl.sv
// Testbench for mem_fill_ctrl: directed scenarios with random addresses, data and
// response gaps, compared cycle by cycle against a transaction-level reference model.
module tb_mem_fill_ctrl;

  localparam int NUM_CH = 2;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int WORDS  = 8;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_CH-1:0]        miss_req;
  logic [NUM_CH*ADDR_W-1:0] miss_addr;
  logic                     mem_en;
  logic [ADDR_W-1:0]        mem_addr;
  logic                     mem_valid;
  logic [DATA_W-1:0]        mem_data;
  logic [NUM_CH-1:0]        fill_valid;
  logic [2:0]               fill_word;
  logic [DATA_W-1:0]        fill_data;
  logic [NUM_CH-1:0]        fill_done;
  logic [NUM_CH-1:0]        stall;

  always #5 clk = ~clk;

  mem_fill_ctrl #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .WORDS  (WORDS),
    .NUM_CH (NUM_CH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .miss_req   (miss_req),
    .miss_addr  (miss_addr),
    .mem_en     (mem_en),
    .mem_addr   (mem_addr),
    .mem_valid  (mem_valid),
    .mem_data   (mem_data),
    .fill_valid (fill_valid),
    .fill_word  (fill_word),
    .fill_data  (fill_data),
    .fill_done  (fill_done),
    .stall      (stall)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: phase 0 = idle, 1 = filling, 2 = one-cycle wait.
  int          m_phase;
  int          m_ch;
  int          m_last;
  int          m_issued;
  int          m_received;
  logic [15:0] m_base;

  int          served_q[$];
  logic [15:0] addr_q[$];
  int          done_cnt;
  int          fv_cnt;
  logic [1:0]  req_cur;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_phase    = 0;
    m_ch       = 0;
    m_last     = NUM_CH - 1;
    m_issued   = 0;
    m_received = 0;
    m_base     = '0;
  endtask

  task automatic clearObs();
    served_q.delete();
    addr_q.delete();
    done_cnt = 0;
    fv_cnt   = 0;
  endtask

  task automatic checkCycle();
    logic        e_en;
    logic [1:0]  e_fv;
    logic [1:0]  e_fd;
    logic [1:0]  e_stall;
    e_en    = (m_phase == 1) && (m_issued < WORDS);
    e_fv    = 2'b00;
    e_fd    = 2'b00;
    if ((m_phase == 1) && mem_valid) begin
      e_fv = 2'(1 << m_ch);
      if (m_received == WORDS - 1) e_fd = e_fv;
    end
    e_stall = miss_req | ((m_phase != 0) ? 2'(1 << m_ch) : 2'b00);
    checkOutput("mem_en", 32'(mem_en), 32'(e_en));
    if (e_en) checkOutput("mem_addr", 32'(mem_addr), 32'(m_base + 16'(2 * m_issued)));
    checkOutput("fill_valid", 32'(fill_valid), 32'(e_fv));
    checkOutput("fill_done", 32'(fill_done), 32'(e_fd));
    checkOutput("stall", 32'(stall), 32'(e_stall));
    if (e_fv != 2'b00) begin
      checkOutput("fill_word", 32'(fill_word), 32'(m_received));
      checkOutput("fill_data", 32'(fill_data), 32'(mem_data));
    end
    if (fill_done != 2'b00) begin
      served_q.push_back(fill_done[1] ? 1 : 0);
      done_cnt++;
    end
    if (fill_valid != 2'b00) fv_cnt++;
    if (mem_en) addr_q.push_back(mem_addr);
  endtask

  task automatic modelStep();
    int c;
    if (rst) begin
      modelReset();
    end else begin
      case (m_phase)
        0: begin
          if (miss_req != 2'b00) begin
            c = (m_last + 1) % NUM_CH;
            if (!miss_req[c]) c = (m_last + 2) % NUM_CH;
            m_ch       = c;
            m_last     = c;
            m_base     = miss_addr[c*ADDR_W +: ADDR_W] & 16'hFFF0;
            m_issued   = 0;
            m_received = 0;
            m_phase    = 1;
          end
        end
        1: begin
          if (m_issued < WORDS) m_issued++;
          if (mem_valid) begin
            m_received++;
            if (m_received == WORDS) m_phase = 2;
          end
        end
        default: m_phase = 0;
      endcase
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [1:0] req, input logic [15:0] a0,
                               input logic [15:0] a1, input logic mv, input logic [15:0] md);
    @(negedge clk);
    rst       = r;
    miss_req  = req;
    miss_addr = {a1, a0};
    mem_valid = mv;
    mem_data  = md;
    #1;
    checkCycle();
    @(posedge clk);
    modelStep();
  endtask

  // Requester holds each request until its fill_done; mode 0 = back-to-back
  // responses, 1 = 1,0,0 pattern, 2 = random gaps. drop_after >= 0 releases early.
  task automatic runFill(input logic [1:0] req, input logic [15:0] a0, input logic [15:0] a1,
                         input int mode, input int drop_after);
    int   k;
    logic mv;
    logic ok;
    k       = 0;
    ok      = 1'b0;
    req_cur = req;
    for (int cyc = 0; cyc < 300; cyc++) begin
      mv = 1'b0;
      if ((m_phase == 1) && (m_received < m_issued)) begin
        case (mode)
          0:       mv = 1'b1;
          1:       mv = ((k % 3) == 0);
          default: mv = 1'($urandom_range(0, 1));
        endcase
        k++;
      end
      if ((drop_after >= 0) && (m_phase == 1) && (m_received >= drop_after)) req_cur[m_ch] = 1'b0;
      applyStimulus(1'b0, req_cur, a0, a1, mv, 16'($urandom));
      if (m_phase == 2) req_cur[m_ch] = 1'b0;
      if ((m_phase == 0) && (req_cur == 2'b00)) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput("fill_timeout", 32'(ok), 32'd1);
  endtask

  initial begin
    logic [15:0] ra;
    rst       = 1'b1;
    miss_req  = '0;
    miss_addr = '0;
    mem_valid = 1'b0;
    mem_data  = '0;
    repeat (2) @(posedge clk);
    modelReset();
    clearObs();

    // Idle after reset, then stray memory responses with no miss pending.
    repeat (2) applyStimulus(1'b0, 2'b00, 16'h0, 16'h0, 1'b0, 16'h0);
    repeat (3) applyStimulus(1'b0, 2'b00, 16'h0, 16'h0, 1'b1, 16'($urandom));
    checkOutput("idle_valid_count", 32'(fv_cnt), 32'd0);

    // Single D-cache miss at 0x1234.
    clearObs();
    runFill(2'b10, 16'h0000, 16'h1234, 0, -1);
    checkOutput("c_addr_count", 32'(addr_q.size()), 32'd8);
    for (int i = 0; i < addr_q.size(); i++)
      checkOutput("c_addr", 32'(addr_q[i]), 32'h1230 + 32'(2 * i));
    checkOutput("c_done_count", 32'(done_cnt), 32'd1);
    checkOutput("c_word_count", 32'(fv_cnt), 32'd8);
    if (served_q.size() > 0) checkOutput("c_served", 32'(served_q[0]), 32'd1);

    // Both channels after reset: ch0, ch1, then ch0 again.
    applyStimulus(1'b1, 2'b00, 16'h0, 16'h0, 1'b0, 16'h0);
    clearObs();
    runFill(2'b11, 16'($urandom), 16'($urandom), 2, -1);
    runFill(2'b11, 16'($urandom), 16'($urandom), 2, -1);
    checkOutput("rr_served_count", 32'(served_q.size()), 32'd4);
    for (int i = 0; i < served_q.size(); i++)
      checkOutput("rr_served_order", 32'(served_q[i]), 32'(i % 2));

    // Gapped responses 1,0,0,...
    clearObs();
    runFill(2'b01, 16'($urandom), 16'h0, 1, -1);
    checkOutput("gap_word_count", 32'(fv_cnt), 32'd8);
    checkOutput("gap_done_count", 32'(done_cnt), 32'd1);

    // Request withdrawn after two words must not abort the fill.
    clearObs();
    runFill(2'b01, 16'($urandom), 16'h0, 0, 2);
    checkOutput("drop_word_count", 32'(fv_cnt), 32'd8);
    checkOutput("drop_done_count", 32'(done_cnt), 32'd1);

    // Reset after three words; late responses are ignored, next miss starts fresh.
    clearObs();
    ra = 16'($urandom);
    for (int cyc = 0; cyc < 50; cyc++) begin
      applyStimulus(1'b0, 2'b01, ra, 16'h0, 1'((m_phase == 1) && (m_received < m_issued)),
                    16'($urandom));
      if (m_received == 3) break;
    end
    checkOutput("rst_words_before", 32'(fv_cnt), 32'd3);
    applyStimulus(1'b1, 2'b00, 16'h0, 16'h0, 1'b0, 16'h0);
    fv_cnt = 0;
    repeat (5) applyStimulus(1'b0, 2'b00, 16'h0, 16'h0, 1'b1, 16'($urandom));
    checkOutput("rst_late_valid", 32'(fv_cnt), 32'd0);
    clearObs();
    runFill(2'b01, 16'($urandom), 16'h0, 0, -1);
    checkOutput("rst_refill_words", 32'(fv_cnt), 32'd8);

    // Random traffic.
    for (int n = 0; n < 6; n++) begin
      runFill(2'($urandom_range(1, 3)), 16'($urandom), 16'($urandom), 2,
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_fill_ctrl.md
MEM_FILL_CTRL -- requirements
Module: mem_fill_ctrl

Interface
REQ-001 Parameter DATA_W, default 16, word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 16, byte-address width.
REQ-003 Parameter WORDS, default 8, words per cache block; SHALL be a power of 2, >= 2.
REQ-004 Parameter NUM_CH, default 2, requester channels (ch0 = I-cache, ch1 = D-cache at default).
REQ-005 One clock; reset is synchronous and active-high. Ports:
- clk  in  1  system clock; all state updates on its rising edge
- rst  in  1  synchronous active-high reset
- miss_req  in  NUM_CH  per-channel miss request; requester holds it until fill_done
- miss_addr  in  NUM_CH*ADDR_W  per-channel miss byte address; ch c occupies bits [c*ADDR_W +: ADDR_W]
- mem_en  out  1  memory read strobe, one address per cycle
- mem_addr  out  ADDR_W  memory read byte address
- mem_valid  in  1  memory returns one word this cycle, in issue order
- mem_data  in  DATA_W  returned word
- fill_valid  out  NUM_CH  one-hot write strobe into the granted channel's cache
- fill_word  out  log2(WORDS)  word index within the block for fill_data
- fill_data  out  DATA_W  word to write
- fill_done  out  NUM_CH  one-cycle pulse on the granted channel with its last word
- stall  out  NUM_CH  pipeline stall per channel

Function
REQ-006 FSM states: IDLE, FILL, WAIT.
REQ-007 IDLE: if any miss_req bit is set, the FSM SHALL latch a round-robin grant, latch block_base, and enter FILL on the next edge.
REQ-008 block_base SHALL equal miss_addr of the granted channel with the low log2(WORDS*DATA_W/8) bits cleared.
REQ-009 Round-robin: the channel after the last granted one has highest priority; after reset, ch0 has highest priority.
REQ-010 FILL issue: mem_en SHALL be high on WORDS consecutive cycles starting the first FILL cycle, with mem_addr = block_base + i*(DATA_W/8) for i = 0..WORDS-1; mem_en SHALL be low otherwise.
REQ-011 FILL receive: on each mem_valid cycle, fill_valid[grant] = 1, fill_data = mem_data, fill_word = receive count; the receive count then increments.
REQ-012 Gaps in mem_valid are legal; fill_word SHALL advance only on mem_valid.
REQ-013 On the mem_valid cycle with receive count WORDS-1, fill_done[grant] SHALL pulse in the same cycle and the FSM SHALL enter WAIT.
REQ-014 WAIT lasts exactly one cycle, then IDLE; no grant is made in WAIT.
REQ-015 fill_valid, fill_done, fill_word and fill_data SHALL be combinational from mem_valid and mem_data in FILL; fill_valid and fill_done SHALL be 0 outside FILL.
REQ-016 mem_valid in IDLE or WAIT SHALL be ignored.
REQ-017 Deassertion of miss_req during FILL SHALL NOT abort the fill.
REQ-018 stall[c] = miss_req[c] OR (state != IDLE AND grant == c).
REQ-019 Counters SHALL be wide enough that WORDS-1 is reached without wrap.

Reset
REQ-020 On rst: state = IDLE, counters = 0, grant = 0, RR priority = ch0, block_base = 0.
REQ-021 Effect of rst: mem_en, fill_valid and fill_done are 0 from the next cycle, and stall reflects only miss_req.
REQ-022 Reset mid-fill SHALL discard the fill; late mem_valid after reset SHALL be ignored.

Structure
REQ-023 Shared package mem_fill_pkg: state enum (IDLE/FILL/WAIT) and default parameter constants.
REQ-024 Sub-module rr_arbiter (NUM_CH-wide request, one-hot grant, priority pointer updated on accept).

Verification
REQ-025 Defaults; miss_req[1] with addr 0x1234 -> mem_addr 0x1230, 0x1232 … 0x123E on 8 consecutive cycles starting the cycle after the request; fill_word 0..7 with matching data; a single fill_done[1].
REQ-026 After reset, miss_req = 2'b11 held -> ch0 served first, then ch1; both re-raised -> ch0 served next.
REQ-027 mem_valid pattern 1,0,0,1,… (8 ones) -> fill_word advances only on ones; fill_done on the 8th word.
REQ-028 rst pulsed after 3 words -> next cycle all outputs 0; 5 later mem_valid pulses produce no fill_valid; a new miss starts at fill_word 0.
REQ-029 miss_req[0] dropped after 2 words -> all 8 words still delivered and fill_done[0] pulses.
REQ-030 mem_valid = 1 in IDLE with no miss -> fill_valid and fill_done stay 0.
